data_mem_stage: RTL and testbench



---
 rtl/data_mem_stage.sv | 58 +++++
 tb/tb_data_mem_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM stage with a big-endian byte/word data RAM and the MEM/WB pipeline register
module data_mem_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              R,
  input  logic              MEM_load_instr,
  input  logic              MEM_RF_enable,
  input  logic              MEM_Size_enable,
  input  logic              MEM_RW_enable,
  input  logic              MEM_Enable_signal,
  input  logic              MEM_hold,
  input  logic [DATA_W-1:0] MEM_alu_out,
  input  logic [DATA_W-1:0] MEM_store_data,
  input  logic [3:0]        MEM_Rd,
  output logic              WB_RF_enable,
  output logic [3:0]        WB_Rd,
  output logic [DATA_W-1:0] WB_data,
  output logic              WB_misaligned
);
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [DATA_W-1:0] rdata;
  logic we, ld, st;
  always_comb begin
    a0 = MEM_alu_out[ADDR_W-1:0];
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
    st = MEM_Enable_signal & MEM_RW_enable;
    we = st & ~MEM_hold;
    ld = MEM_Enable_signal & ~MEM_RW_enable & MEM_load_instr;
    rdata = MEM_Size_enable ? {mem[a0], mem[a1], mem[a2], mem[a3]} : {{(DATA_W-8){1'b0}}, mem[a0]};
  end
  always_ff @(posedge clk)
    if (R && we) begin
      if (MEM_Size_enable) begin
        mem[a0] <= MEM_store_data[31:24];
        mem[a1] <= MEM_store_data[23:16];
        mem[a2] <= MEM_store_data[15:8];
        mem[a3] <= MEM_store_data[7:0];
      end else
        mem[a0] <= MEM_store_data[7:0];
    end
  always_ff @(posedge clk or negedge R)
    if (!R) begin
      WB_RF_enable  <= 1'b0;
      WB_Rd         <= '0;
      WB_data       <= '0;
      WB_misaligned <= 1'b0;
    end else if (!MEM_hold) begin
      WB_RF_enable  <= MEM_RF_enable & ~st;
      WB_Rd         <= MEM_Rd;
      WB_data       <= ld ? rdata : MEM_alu_out;
      WB_misaligned <= MEM_Enable_signal & MEM_Size_enable & (a0[1:0] != 2'b00);
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: directed and random checks of data_mem_stage against a byte-array model
module tb_data_mem_stage;
  logic clk = 1'b0;
  logic R = 1'b1;
  logic ld, rf, sz, rw, en, hd;
  logic [31:0] alu, sd;
  logic [3:0] rd;
  logic wb_rf, wb_mis;
  logic [3:0] wb_rd;
  logic [31:0] wb_data;
  int tests = 0, fails = 0;
  logic [7:0] m [256];
  logic rv = 1'b1;
  logic e_rf = 1'b0, e_mis = 1'b0;
  logic [3:0] e_rd = '0;
  logic [31:0] e_data = '0;

  data_mem_stage dut (
    .clk(clk), .R(R), .MEM_load_instr(ld), .MEM_RF_enable(rf), .MEM_Size_enable(sz),
    .MEM_RW_enable(rw), .MEM_Enable_signal(en), .MEM_hold(hd), .MEM_alu_out(alu),
    .MEM_store_data(sd), .MEM_Rd(rd), .WB_RF_enable(wb_rf), .WB_Rd(wb_rd),
    .WB_data(wb_data), .WB_misaligned(wb_mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int a, input logic word);
    return word ? {m[a], m[(a+1)%256], m[(a+2)%256], m[(a+3)%256]} : {24'h0, m[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic l, f, s, w, e, h, input logic [31:0] al, st, input logic [3:0] r);
    int a;
    logic [31:0] rdv;
    @(negedge clk);
    R = rv; ld = l; rf = f; sz = s; rw = w; en = e; hd = h; alu = al; sd = st; rd = r;
    a = int'(al[7:0]);
    rdv = model_read(a, s);
    if (!rv) begin
      e_rf = 0; e_rd = 0; e_data = 0; e_mis = 0;
    end else if (!h) begin
      e_data = (e && !w && l) ? rdv : al;
      e_rf = f && !(e && w);
      e_rd = r;
      e_mis = e && s && (a % 4 != 0);
      if (e && w) begin
        if (s) for (int i = 0; i < 4; i++) m[(a+i)%256] = st[31-8*i -: 8];
        else m[a] = st[7:0];
      end
    end
    @(posedge clk);
    #1;
    check("wb_rf", {31'b0, wb_rf}, {31'b0, e_rf});
    check("wb_rd", {28'b0, wb_rd}, {28'b0, e_rd});
    check("wb_data", wb_data, e_data);
    check("wb_mis", {31'b0, wb_mis}, {31'b0, e_mis});
  endtask

  task automatic store(input logic word, input logic [31:0] a, d);
    step(0, 1, word, 1, 1, 0, a, d, 4'd1);
  endtask

  task automatic load(input logic word, input logic [31:0] a);
    step(1, 1, word, 0, 1, 0, a, 32'h0, 4'd2);
  endtask

  initial begin
    logic [31:0] fz;
    {ld, rf, sz, rw, en, hd, alu, sd, rd} = '0;
    #1 R = 1'b0;
    #1 check("por_data", wb_data, 32'h0);
    check("por_rf", {31'b0, wb_rf}, 32'h0);
    for (int i = 0; i < 64; i++) store(1, 32'(4*i), $urandom);

    step(0, 1, 0, 0, 0, 0, 32'h12345678, 32'h0, 4'd9);
    check("pre_rst_data", wb_data, 32'h12345678);
    @(negedge clk);
    #2 R = 1'b0;
    rv = 1'b0;
    #1 check("async_data", wb_data, 32'h0);
    check("async_rf", {31'b0, wb_rf}, 32'h0);
    check("async_rd", {28'b0, wb_rd}, 32'h0);
    store(1, 32'h10, 32'h11111111);
    rv = 1'b1;
    load(1, 32'h10);

    store(1, 32'h10, 32'hDEADBEEF);
    check("st_rf0", {31'b0, wb_rf}, 32'h0);
    load(1, 32'h10);
    check("ld_word", wb_data, 32'hDEADBEEF);
    check("ld_rf1", {31'b0, wb_rf}, 32'h1);
    load(0, 32'h11);
    check("ld_byte", wb_data, 32'h000000AD);
    store(0, 32'h12, 32'hFFFFFF5A);
    check("stb_rf0", {31'b0, wb_rf}, 32'h0);
    load(1, 32'h10);
    check("ld_merge", wb_data, 32'hDEAD5AEF);

    store(1, 32'h000000FE, 32'h01020304);
    load(1, 32'hFE);
    check("ld_wrap", wb_data, 32'h01020304);
    check("mis_wrap", {31'b0, wb_mis}, 32'h1);
    load(0, 32'hFF);
    check("b_ff", wb_data, 32'h02);
    check("b_mis0", {31'b0, wb_mis}, 32'h0);
    load(0, 32'h1);
    check("b_01", wb_data, 32'h04);
    load(1, 32'hFFFFFF00);
    check("ld_00_hi", {16'h0, wb_data[31:16]}, 32'h0304);
    check("ld_00_mis", {31'b0, wb_mis}, 32'h0);

    step(1, 1, 1, 1, 0, 0, 32'h00000077, 32'hFFFFFFFF, 4'd5);
    check("alu_data", wb_data, 32'h77);
    check("alu_rd", {28'b0, wb_rd}, 32'h5);
    check("alu_rf", {31'b0, wb_rf}, 32'h1);

    fz = wb_data;
    step(0, 1, 1, 1, 1, 1, 32'h20, 32'hAAAAAAAA, 4'd7);
    step(0, 1, 1, 1, 1, 1, 32'h20, 32'hAAAAAAAA, 4'd7);
    check("hold_data", wb_data, fz);
    check("hold_rd", {28'b0, wb_rd}, 32'h5);
    load(1, 32'h20);
    check("hold_nowrite", wb_data == 32'hAAAAAAAA ? 32'h1 : 32'h0, m[32] == 8'hAA ? 32'h1 : 32'h0);
    store(1, 32'h20, 32'hAAAAAAAA);
    load(1, 32'h20);
    check("hold_release", wb_data, 32'hAAAAAAAA);

    store(1, 32'h40, 32'hCAFEF00D);
    check("st_wbdata", wb_data, 32'h40);
    load(1, 32'h40);
    check("b2b", wb_data, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           {$urandom_range(0, 255) << 8, 8'($urandom_range(0, 15) == 0 ? $urandom_range(250, 255) : $urandom_range(0, 63))},
           $urandom, 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
